// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the data-memory controller: access size, FSM states and byte-lane width.
package riscv_definitions;

    typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} dmc_size_t;

    typedef enum logic [1:0] {DMC_IDLE, DMC_REQ, DMC_WAIT, DMC_RESP} dmc_state_t;

    localparam int DMC_BE_WIDTH = 4;

    // The core's 2-bit size field; the unused 11 encoding behaves as a word access.
    function automatic dmc_size_t dmc_decode_size(input logic [1:0] ctrl);
        case (ctrl)
            2'b00:   return SIZE_B;
            2'b01:   return SIZE_H;
            default: return SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_lane_align.sv
// Combinational byte-lane logic: byte enables, replicated store data, load shift/mask, misalign detect.
module dmc_lane_align
    import riscv_definitions::*;
(
    input  logic [1:0]              offset,
    input  logic [1:0]              size_ctrl,
    input  logic [31:0]             store_data,
    input  logic [31:0]             load_data,
    output logic [DMC_BE_WIDTH-1:0] be,
    output logic [31:0]             wdata,
    output logic                    misaligned,
    output logic [31:0]             load_aligned
);

    dmc_size_t   size;
    logic [31:0] shifted;

    always_comb begin
        size         = dmc_decode_size(size_ctrl);
        shifted      = load_data >> {offset, 3'b000};
        be           = '0;
        wdata        = '0;
        misaligned   = 1'b0;
        load_aligned = '0;
        case (size)
            SIZE_B: begin
                be           = 4'b0001 << offset;
                wdata        = {4{store_data[7:0]}};
                load_aligned = {24'h0, shifted[7:0]};
            end
            SIZE_H: begin
                be           = 4'b0011 << offset;
                wdata        = {2{store_data[15:0]}};
                misaligned   = offset[0];
                load_aligned = {16'h0, shifted[15:0]};
            end
            default: begin
                be           = 4'b1111;
                wdata        = store_data;
                misaligned   = |offset;
                load_aligned = shifted;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one load/store per request over a req/gnt/rvalid bus, stalling via o_data_ready.
// Define DMC_WRITE_BUFFER_EN to enable the one-entry posted write buffer.
module data_mem_ctrl
    import riscv_definitions::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_data_rd_en_ma,
    input  logic                    i_data_wr_en_ma,
    input  logic [31:0]             i_data_addr,
    input  logic [31:0]             i_data_wr,
    input  logic [1:0]              i_data_rd_en_ctrl,
    output logic                    o_data_ready,
    output logic [31:0]             o_data_rd,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DMC_BE_WIDTH-1:0] o_mem_be,
    output logic [31:0]             o_mem_wdata,
    input  logic                    i_mem_gnt,
    input  logic                    i_mem_rvalid,
    input  logic [31:0]             i_mem_rdata,
    output logic                    o_misaligned,
    output logic                    o_bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
`ifdef DMC_WRITE_BUFFER_EN
    localparam logic WB_EN = 1'b1;
`else
    localparam logic WB_EN = 1'b0;
`endif

    dmc_state_t              state, state_next;
    logic [CNT_W-1:0]        cnt;
    logic [1:0]              offset_q, size_q;
    logic                    posted;
    logic                    req_any;
    logic [1:0]              lane_offset, lane_size;
    logic [DMC_BE_WIDTH-1:0] lane_be;
    logic [31:0]             lane_wdata, lane_load;
    logic                    lane_misaligned;
    logic                    latch_req, post_store, misalign_evt, capture, timeout_evt;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^i_data_addr[31:ADDR_WIDTH+2];
    assign req_any          = i_data_rd_en_ma | i_data_wr_en_ma;

    // In IDLE the lanes are computed from the live request; afterwards from the latched access.
    assign lane_offset = (state == DMC_IDLE) ? i_data_addr[1:0]  : offset_q;
    assign lane_size   = (state == DMC_IDLE) ? i_data_rd_en_ctrl : size_q;

    dmc_lane_align u_lane_align (
        .offset       (lane_offset),
        .size_ctrl    (lane_size),
        .store_data   (i_data_wr),
        .load_data    (i_mem_rdata),
        .be           (lane_be),
        .wdata        (lane_wdata),
        .misaligned   (lane_misaligned),
        .load_aligned (lane_load)
    );

    always_comb begin
        state_next   = state;
        o_data_ready = 1'b0;
        o_mem_req    = 1'b0;
        latch_req    = 1'b0;
        post_store   = 1'b0;
        misalign_evt = 1'b0;
        capture      = 1'b0;
        timeout_evt  = 1'b0;
        case (state)
            DMC_IDLE: begin
                o_data_ready = !req_any;
                if (req_any) begin
                    latch_req = 1'b1;
                    if (lane_misaligned) begin
                        misalign_evt = 1'b1;
                        state_next   = DMC_RESP;
                    end else begin
                        state_next = DMC_REQ;
                        if (WB_EN && i_data_wr_en_ma) begin
                            post_store   = 1'b1;
                            o_data_ready = 1'b1;
                        end
                    end
                end
            end
            DMC_REQ: begin
                o_mem_req    = 1'b1;
                o_data_ready = posted && !req_any;
                if (i_mem_gnt) state_next = DMC_WAIT;
            end
            DMC_WAIT: begin
                // A drained posted store has already completed for the core, so it skips RESP.
                o_data_ready = posted && !req_any;
                if (i_mem_rvalid) begin
                    capture    = !posted;
                    state_next = posted ? DMC_IDLE : DMC_RESP;
                end else if (cnt == CNT_MAX) begin
                    timeout_evt = 1'b1;
                    state_next  = posted ? DMC_IDLE : DMC_RESP;
                end
            end
            DMC_RESP: begin
                o_data_ready = 1'b1;
                state_next   = DMC_IDLE;
            end
            default: state_next = DMC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= DMC_IDLE;
            cnt          <= '0;
            offset_q     <= '0;
            size_q       <= '0;
            posted       <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_be     <= '0;
            o_mem_wdata  <= '0;
            o_data_rd    <= '0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            state        <= state_next;
            o_misaligned <= misalign_evt;
            o_bus_err    <= timeout_evt;
            cnt          <= (state == DMC_WAIT && state_next == DMC_WAIT) ? cnt + 1'b1 : '0;
            if (latch_req) begin
                offset_q    <= i_data_addr[1:0];
                size_q      <= i_data_rd_en_ctrl;
                posted      <= post_store;
                o_mem_we    <= i_data_wr_en_ma;
                o_mem_addr  <= i_data_addr[ADDR_WIDTH+1:2];
                o_mem_be    <= lane_be;
                o_mem_wdata <= lane_wdata;
            end
            if (misalign_evt || (timeout_evt && !posted)) begin
                o_data_rd <= '0;
            end else if (capture) begin
                o_data_rd <= lane_load;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: vector table with a scoreboard queue plus timeout/reset sequences.
module tb_data_mem_ctrl;

    localparam int AW = 16;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_data_rd_en_ma, i_data_wr_en_ma;
    logic [31:0] i_data_addr, i_data_wr;
    logic [1:0]  i_data_rd_en_ctrl;
    logic        o_data_ready;
    logic [31:0] o_data_rd;
    logic        o_mem_req, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt, i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_misaligned, o_bus_err;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_data_rd_en_ma   (i_data_rd_en_ma),
        .i_data_wr_en_ma   (i_data_wr_en_ma),
        .i_data_addr       (i_data_addr),
        .i_data_wr         (i_data_wr),
        .i_data_rd_en_ctrl (i_data_rd_en_ctrl),
        .o_data_ready      (o_data_ready),
        .o_data_rd         (o_data_rd),
        .o_mem_req         (o_mem_req),
        .o_mem_we          (o_mem_we),
        .o_mem_addr        (o_mem_addr),
        .o_mem_be          (o_mem_be),
        .o_mem_wdata       (o_mem_wdata),
        .i_mem_gnt         (i_mem_gnt),
        .i_mem_rvalid      (i_mem_rvalid),
        .i_mem_rdata       (i_mem_rdata),
        .o_misaligned      (o_misaligned),
        .o_bus_err         (o_bus_err)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        int          stall;
        logic        mis;
        logic        bus;
        logic [15:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        chk_rd;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem [0:255];
    logic        rvalid_en;
    exp_t        sb_q[$];
    vec_t        vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [1:0] size, input logic [31:0] wdata, input logic [31:0] exp_rd,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata, input logic exp_mis);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_mis = exp_mis;
        return v;
    endfunction

    // Memory model: grant is always offered; a granted access answers with rvalid in the next cycle.
    initial begin
        logic       fire, we;
        logic [7:0] a;
        logic [3:0] be;
        logic [31:0] wd;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            fire = o_mem_req && rst_n;
            a = o_mem_addr[7:0]; we = o_mem_we; be = o_mem_be; wd = o_mem_wdata;
            @(posedge clk);
            #1;
            i_mem_rvalid = 1'b0;
            if (fire && rvalid_en && rst_n) begin
                if (we) begin
                    for (int b = 0; b < 4; b++) if (be[b]) mem[a][8*b +: 8] = wd[8*b +: 8];
                end
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = we ? 32'h0 : mem[a];
            end
        end
    end

    task automatic waitReady(output int stall, output logic saw, output logic [15:0] ma,
                             output logic [3:0] mbe, output logic mwe, output logic [31:0] mwd);
        stall = 0; saw = 1'b0; ma = '0; mbe = '0; mwe = 1'b0; mwd = '0;
        while (stall < 50) begin
            @(negedge clk);
            if (o_mem_req && !saw) begin
                saw = 1'b1; ma = o_mem_addr; mbe = o_mem_be; mwe = o_mem_we; mwd = o_mem_wdata;
            end
            if (o_data_ready) break;
            stall++;
        end
    endtask

    task automatic applyStimulus(input string tag, input vec_t v);
        exp_t        e;
        int          stall;
        logic        saw, mwe;
        logic [15:0] ma;
        logic [3:0]  mbe;
        logic [31:0] mwd;
        @(posedge clk);
        #1;
        i_data_rd_en_ma = v.rd; i_data_wr_en_ma = v.wr; i_data_addr = v.addr;
        i_data_rd_en_ctrl = v.size; i_data_wr = v.wdata;
        e.rd = v.exp_rd; e.stall = v.exp_mis ? 1 : 3; e.mis = v.exp_mis; e.bus = !v.exp_mis;
        e.addr = v.addr[17:2]; e.be = v.exp_be; e.we = v.wr; e.wdata = v.exp_wdata; e.chk_rd = v.rd;
        sb_q.push_back(e);
        waitReady(stall, saw, ma, mbe, mwe, mwd);
        e = sb_q.pop_front();
        checkOutput({tag, ".stall"}, stall, e.stall);
        checkOutput({tag, ".misaligned"}, o_misaligned, e.mis);
        checkOutput({tag, ".bus_err"}, o_bus_err, 1'b0);
        checkOutput({tag, ".req_seen"}, saw, e.bus);
        if (e.bus) begin
            checkOutput({tag, ".mem_addr"}, ma, e.addr);
            checkOutput({tag, ".mem_be"}, mbe, e.be);
            checkOutput({tag, ".mem_we"}, mwe, e.we);
            if (e.we) checkOutput({tag, ".mem_wdata"}, mwd, e.wdata);
        end
        if (e.chk_rd) checkOutput({tag, ".data_rd"}, o_data_rd, e.rd);
        @(posedge clk);
        #1;
        i_data_rd_en_ma = 1'b0; i_data_wr_en_ma = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          stall;
        logic        saw, mwe;
        logic [15:0] ma;
        logic [3:0]  mbe;
        logic [31:0] mwd;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'hDEADBEEF;
        mem[8'h01] = 32'h11223344;
        rvalid_en = 1'b1;
        i_mem_gnt = 1'b1;
        rst_n = 1'b0;
        i_data_rd_en_ma = 1'b0; i_data_wr_en_ma = 1'b0; i_data_addr = 32'h0;
        i_data_wr = 32'h0; i_data_rd_en_ctrl = 2'b00;

        #22;
        checkOutput("reset.ready", o_data_ready, 1'b1);
        checkOutput("reset.data_rd", o_data_rd, 32'h0);
        checkOutput("reset.req", o_mem_req, 1'b0);
        checkOutput("reset.we", o_mem_we, 1'b0);
        checkOutput("reset.addr", o_mem_addr, 16'h0);
        checkOutput("reset.be", o_mem_be, 4'h0);
        checkOutput("reset.wdata", o_mem_wdata, 32'h0);
        checkOutput("reset.misaligned", o_misaligned, 1'b0);
        checkOutput("reset.bus_err", o_bus_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DMC_WRITE_BUFFER_EN
        @(posedge clk);
        #1;
        i_data_wr_en_ma = 1'b1; i_data_addr = 32'h10; i_data_rd_en_ctrl = 2'b10; i_data_wr = 32'h55AA1234;
        @(negedge clk);
        checkOutput("wb.store_no_stall", o_data_ready, 1'b1);
        @(posedge clk);
        #1;
        i_data_wr_en_ma = 1'b0; i_data_rd_en_ma = 1'b1;
        waitReady(stall, saw, ma, mbe, mwe, mwd);
        checkOutput("wb.load_stall", stall, 5);
        checkOutput("wb.load_data", o_data_rd, 32'h55AA1234);
        @(posedge clk);
        #1;
        i_data_rd_en_ma = 1'b0;
`else
        vecs.push_back(mk(1, 0, 32'h100, 2'b10, 0, 32'hDEADBEEF, 4'hF, 0, 0));
        vecs.push_back(mk(1, 0, 32'h103, 2'b00, 0, 32'h000000DE, 4'h8, 0, 0));
        vecs.push_back(mk(1, 0, 32'h102, 2'b01, 0, 32'h0000DEAD, 4'hC, 0, 0));
        vecs.push_back(mk(1, 0, 32'h101, 2'b00, 0, 32'h000000BE, 4'h2, 0, 0));
        vecs.push_back(mk(1, 0, 32'h100, 2'b01, 0, 32'h0000BEEF, 4'h3, 0, 0));
        vecs.push_back(mk(1, 0, 32'h100, 2'b11, 0, 32'hDEADBEEF, 4'hF, 0, 0));
        vecs.push_back(mk(0, 1, 32'h006, 2'b01, 32'h1234ABCD, 0, 4'hC, 32'hABCDABCD, 0));
        vecs.push_back(mk(1, 0, 32'h004, 2'b10, 0, 32'hABCD3344, 4'hF, 0, 0));
        vecs.push_back(mk(0, 1, 32'h009, 2'b00, 32'h000000A5, 0, 4'h2, 32'hA5A5A5A5, 0));
        vecs.push_back(mk(1, 0, 32'h008, 2'b10, 0, 32'h0000A500, 4'hF, 0, 0));
        vecs.push_back(mk(0, 1, 32'h00C, 2'b10, 32'hCAFEF00D, 0, 4'hF, 32'hCAFEF00D, 0));
        vecs.push_back(mk(1, 0, 32'h00C, 2'b10, 0, 32'hCAFEF00D, 4'hF, 0, 0));
        vecs.push_back(mk(1, 0, 32'h102, 2'b10, 0, 32'h0, 4'h0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h101, 2'b01, 0, 32'h0, 4'h0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h00E, 2'b10, 32'h99999999, 0, 4'h0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h00C, 2'b10, 0, 32'hCAFEF00D, 4'hF, 0, 0));
        vecs.push_back(mk(1, 0, 32'h102, 2'b00, 0, 32'h000000AD, 4'h4, 0, 0));
        foreach (vecs[i]) applyStimulus($sformatf("vec%0d", i), vecs[i]);
`endif

        // Memory never answers: the access must be force-completed with a bus error.
        rvalid_en = 1'b0;
        @(posedge clk);
        #1;
        i_data_rd_en_ma = 1'b1; i_data_addr = 32'h100; i_data_rd_en_ctrl = 2'b10;
        waitReady(stall, saw, ma, mbe, mwe, mwd);
        checkOutput("timeout.stall_range", (stall >= TO + 2 && stall <= TO + 4), 1'b1);
        checkOutput("timeout.bus_err", o_bus_err, 1'b1);
        checkOutput("timeout.data_rd", o_data_rd, 32'h0);
        checkOutput("timeout.misaligned", o_misaligned, 1'b0);
        @(posedge clk);
        #1;
        i_data_rd_en_ma = 1'b0;
        @(negedge clk);
        checkOutput("timeout.err_pulse", o_bus_err, 1'b0);
        checkOutput("timeout.idle_ready", o_data_ready, 1'b1);

        // Reset asserted while the access sits in WAIT abandons it.
        @(posedge clk);
        #1;
        i_data_rd_en_ma = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstwait.req_in_req", o_mem_req, 1'b1);
        @(negedge clk);
        checkOutput("rstwait.stalled", o_data_ready, 1'b0);
        i_data_rd_en_ma = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rstwait.req", o_mem_req, 1'b0);
        checkOutput("rstwait.ready", o_data_ready, 1'b1);
        checkOutput("rstwait.be", o_mem_be, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rvalid_en = 1'b1;
        @(negedge clk);
        checkOutput("rstwait.no_retry", o_mem_req, 1'b0);
        applyStimulus("recover", mk(1, 0, 32'h100, 2'b10, 0, 32'hDEADBEEF, 4'hF, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
